// File: rtl/msrh_pred_upd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msrh_pred_upd_sched                                          |
// | Description : Schedules branch-resolution updates onto the single-ported   |
// |               BTB/BIM SRAM write port. Updates are queued in a FIFO and    |
// |               drained whenever the frontend s0 search leaves the port      |
// |               free. After STARVE_MAX blocked cycles a forced drain takes   |
// |               the port and stalls search for that one cycle.               |
// | Ports       : i_clk/i_reset            clock, async active-high reset      |
// |               i_upd_* / o_upd_ready    branch update push interface        |
// |               i_s0_search              frontend requests the SRAM port     |
// |               o_search_stall           search denied (forced drain cycle)  |
// |               o_btb_upd_*              registered BTB write request        |
// |               o_bim_upd_*              registered BIM write request        |
// |               o_q_count                FIFO occupancy                      |
// | Option      : `define MSRH_UPD_COALESCE_EN merges a push whose pc matches  |
// |               the newest queued entry into that entry.                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module msrh_pred_upd_sched #(
  parameter int Q_DEPTH    = 4,
  parameter int STARVE_MAX = 8,
  // Matches riscv_pkg::VADDR_W of the core this block ships with.
  parameter int VADDR_W    = 39
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_upd_valid,
  output logic                     o_upd_ready,
  input  logic [VADDR_W-1:0]       i_upd_pc,
  input  logic [VADDR_W-1:0]       i_upd_target,
  input  logic                     i_upd_taken,
  input  logic                     i_upd_is_cond,
  input  logic                     i_s0_search,
  output logic                     o_search_stall,
  output logic                     o_btb_upd_valid,
  output logic [VADDR_W-1:0]       o_btb_upd_pc,
  output logic [VADDR_W-1:0]       o_btb_upd_target,
  output logic                     o_bim_upd_valid,
  output logic [VADDR_W-1:0]       o_bim_upd_pc,
  output logic                     o_bim_upd_taken,
  output logic [$clog2(Q_DEPTH):0] o_q_count
);

  localparam int c_aw = $clog2(Q_DEPTH);
  localparam int c_pw = c_aw + 1;
  localparam int c_sw = $clog2(STARVE_MAX) + 1;
  localparam logic [c_sw-1:0] c_starve_last = c_sw'(STARVE_MAX - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_drain = 2'd1;
  localparam logic [1:0] c_st_force = 2'd2;

  // FIFO storage
  logic [VADDR_W-1:0] r_mem_pc     [Q_DEPTH];
  logic [VADDR_W-1:0] r_mem_target [Q_DEPTH];
  logic               r_mem_taken  [Q_DEPTH];
  logic               r_mem_cond   [Q_DEPTH];

  logic [c_pw-1:0] r_wr_ptr;
  logic [c_pw-1:0] r_rd_ptr;
  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [c_sw-1:0] r_starve_cnt;
  logic [c_sw-1:0] w_starve_inc;

  logic [c_aw-1:0] w_head_idx;
  logic [c_aw-1:0] w_tail_idx;
  logic [c_pw-1:0] w_count;
  logic [c_pw-1:0] w_count_nxt;
  logic            w_empty;
  logic            w_full;
  logic            w_head_vld;
  logic            w_pop;
  logic            w_alloc;
  logic            w_ready;
  logic            w_blocked;
  logic            w_search_stall;

  logic               r_btb_valid;
  logic [VADDR_W-1:0] r_btb_pc;
  logic [VADDR_W-1:0] r_btb_target;
  logic               r_bim_valid;
  logic [VADDR_W-1:0] r_bim_pc;
  logic               r_bim_taken;

  assign w_head_idx = r_rd_ptr[c_aw-1:0];
  assign w_tail_idx = r_wr_ptr[c_aw-1:0];
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  // Same slot, opposite lap: the writer is a full lap ahead.
  assign w_full     = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                      (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_head_vld = !w_empty;
  assign w_pop      = w_head_vld && (!i_s0_search || (r_state == c_st_force));
  assign w_blocked  = (r_state == c_st_drain) && w_head_vld && i_s0_search;

`ifdef MSRH_UPD_COALESCE_EN
  logic [c_aw-1:0] w_newest_idx;
  logic            w_coal_hit;
  assign w_newest_idx = w_tail_idx - 1'b1;
  // The newest entry may only be merged into if it is not leaving as the
  // head this very cycle; otherwise the update would be lost.
  assign w_coal_hit   = i_upd_valid && w_head_vld &&
                        (r_mem_pc[w_newest_idx] == i_upd_pc) &&
                        !(w_pop && (w_count == c_pw'(1)));
  assign w_ready      = !w_full || w_coal_hit;
  assign w_alloc      = i_upd_valid && !w_full && !w_coal_hit;
`else
  assign w_ready      = !w_full;
  assign w_alloc      = i_upd_valid && !w_full;
`endif

  assign w_count_nxt  = w_count + c_pw'(w_alloc) - c_pw'(w_pop);
  assign w_starve_inc = r_starve_cnt + 1'b1;

  // Storage needs no reset: the pointers define which slots are live.
  always_ff @(posedge i_clk) begin
    if (w_alloc) begin
      r_mem_pc[w_tail_idx]     <= i_upd_pc;
      r_mem_target[w_tail_idx] <= i_upd_target;
      r_mem_taken[w_tail_idx]  <= i_upd_taken;
      r_mem_cond[w_tail_idx]   <= i_upd_is_cond;
    end
`ifdef MSRH_UPD_COALESCE_EN
    else if (w_coal_hit) begin
      r_mem_target[w_newest_idx] <= i_upd_target;
      r_mem_taken[w_newest_idx]  <= i_upd_taken;
      r_mem_cond[w_newest_idx]   <= i_upd_is_cond;
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_alloc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // State register and starvation counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= c_st_idle;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      // Any cycle that is not a blocked drain cycle (a pop, idle, or the
      // forced cycle itself) restarts the starvation window.
      r_starve_cnt <= w_blocked ? w_starve_inc : '0;
    end
  end

  // Next-state logic. IDLE is held exactly while the FIFO is empty.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_count_nxt != '0) w_state_nxt = c_st_drain;
      end
      c_st_drain: begin
        if (w_count_nxt == '0)
          w_state_nxt = c_st_idle;
        else if (w_blocked && (w_starve_inc >= c_starve_last))
          w_state_nxt = c_st_force;
      end
      c_st_force: begin
        w_state_nxt = (w_count_nxt != '0) ? c_st_drain : c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    w_search_stall = 1'b0;
    if (r_state == c_st_force) w_search_stall = i_s0_search;
  end

  // Write request registers: one strobe cycle per popped entry.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_btb_valid  <= 1'b0;
      r_btb_pc     <= '0;
      r_btb_target <= '0;
      r_bim_valid  <= 1'b0;
      r_bim_pc     <= '0;
      r_bim_taken  <= 1'b0;
    end else if (w_pop) begin
      r_btb_valid  <= r_mem_taken[w_head_idx];
      r_btb_pc     <= r_mem_pc[w_head_idx];
      r_btb_target <= r_mem_target[w_head_idx];
      r_bim_valid  <= r_mem_cond[w_head_idx];
      r_bim_pc     <= r_mem_pc[w_head_idx];
      r_bim_taken  <= r_mem_taken[w_head_idx];
    end else begin
      r_btb_valid  <= 1'b0;
      r_bim_valid  <= 1'b0;
    end
  end

  assign o_upd_ready      = w_ready;
  assign o_search_stall   = w_search_stall;
  assign o_btb_upd_valid  = r_btb_valid;
  assign o_btb_upd_pc     = r_btb_pc;
  assign o_btb_upd_target = r_btb_target;
  assign o_bim_upd_valid  = r_bim_valid;
  assign o_bim_upd_pc     = r_bim_pc;
  assign o_bim_upd_taken  = r_bim_taken;
  assign o_q_count        = w_count;

endmodule
`default_nettype wire

// File: tb/tb_msrh_pred_upd_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_msrh_pred_upd_sched                                       |
// | Description : Self-checking bench for msrh_pred_upd_sched: directed vector |
// |               table, starvation/reset/coalesce sequences, and a random     |
// |               run against a queue-based reference model.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_msrh_pred_upd_sched;

  localparam int Q_DEPTH    = 4;
  localparam int STARVE_MAX = 8;
  localparam int VADDR_W    = 32;
  localparam int CW         = $clog2(Q_DEPTH) + 1;

  logic               i_clk = 1'b0;
  logic               i_reset = 1'b1;
  logic               i_upd_valid = 1'b0;
  logic               o_upd_ready;
  logic [VADDR_W-1:0] i_upd_pc = '0;
  logic [VADDR_W-1:0] i_upd_target = '0;
  logic               i_upd_taken = 1'b0;
  logic               i_upd_is_cond = 1'b0;
  logic               i_s0_search = 1'b0;
  logic               o_search_stall;
  logic               o_btb_upd_valid;
  logic [VADDR_W-1:0] o_btb_upd_pc;
  logic [VADDR_W-1:0] o_btb_upd_target;
  logic               o_bim_upd_valid;
  logic [VADDR_W-1:0] o_bim_upd_pc;
  logic               o_bim_upd_taken;
  logic [CW-1:0]      o_q_count;

  always #5 i_clk = ~i_clk;

  msrh_pred_upd_sched #(
    .Q_DEPTH   (Q_DEPTH),
    .STARVE_MAX(STARVE_MAX),
    .VADDR_W   (VADDR_W)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_upd_valid     (i_upd_valid),
    .o_upd_ready     (o_upd_ready),
    .i_upd_pc        (i_upd_pc),
    .i_upd_target    (i_upd_target),
    .i_upd_taken     (i_upd_taken),
    .i_upd_is_cond   (i_upd_is_cond),
    .i_s0_search     (i_s0_search),
    .o_search_stall  (o_search_stall),
    .o_btb_upd_valid (o_btb_upd_valid),
    .o_btb_upd_pc    (o_btb_upd_pc),
    .o_btb_upd_target(o_btb_upd_target),
    .o_bim_upd_valid (o_bim_upd_valid),
    .o_bim_upd_pc    (o_bim_upd_pc),
    .o_bim_upd_taken (o_bim_upd_taken),
    .o_q_count       (o_q_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        v;
    logic [31:0] pc, tgt;
    logic        tk, cd, s;
    logic        e_rdy;
    int          e_cnt;
    logic        e_stall, e_btb, e_bim;
    logic [31:0] e_pc, e_tgt;
    logic        e_tk;
  } vec_t;

  typedef struct {
    logic [31:0] pc, tgt;
    logic        tk, cd;
  } ent_t;

  vec_t tbl[20];

  // reference model state
  ent_t        m_q[$];
  int          m_wait;
  logic        m_btb, m_bim, m_tk;
  logic [31:0] m_pc, m_tgt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply inputs on the falling edge, settle, then return for checking.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic tk, input logic cd, input logic s);
    @(negedge i_clk);
    i_upd_valid   = v;
    i_upd_pc      = pc;
    i_upd_target  = tgt;
    i_upd_taken   = tk;
    i_upd_is_cond = cd;
    i_s0_search   = s;
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_upd_valid = 1'b0;
    i_s0_search = 1'b0;
    i_reset     = 1'b1;
    @(negedge i_clk);
    i_reset     = 1'b0;
    m_q.delete();
    m_wait = 0;
    m_btb  = 1'b0;
    m_bim  = 1'b0;
  endtask

  // One cycle of the reference model: check current outputs, then advance.
  task automatic model_cycle(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                             input logic tk, input logic cd, input logic s);
    bit   head, forced, pop, rdy;
    ent_t e;
    head   = (m_q.size() > 0);
    forced = head && (m_wait >= STARVE_MAX - 1);
    pop    = head && (!s || forced);
    rdy    = (m_q.size() < Q_DEPTH);
    chk("rnd_ready", o_upd_ready, rdy);
    chk("rnd_count", o_q_count, m_q.size());
    chk("rnd_stall", o_search_stall, forced && s);
    chk("rnd_btb_v", o_btb_upd_valid, m_btb);
    chk("rnd_bim_v", o_bim_upd_valid, m_bim);
    if (m_btb) begin
      chk("rnd_btb_pc", o_btb_upd_pc, m_pc);
      chk("rnd_btb_tgt", o_btb_upd_target, m_tgt);
    end
    if (m_bim) begin
      chk("rnd_bim_pc", o_bim_upd_pc, m_pc);
      chk("rnd_bim_tk", o_bim_upd_taken, m_tk);
    end
    if (pop) begin
      e      = m_q.pop_front();
      m_btb  = e.tk;
      m_bim  = e.cd;
      m_pc   = e.pc;
      m_tgt  = e.tgt;
      m_tk   = e.tk;
      m_wait = 0;
    end else begin
      m_btb = 1'b0;
      m_bim = 1'b0;
      if (head && s) m_wait++;
      else           m_wait = 0;
    end
    if (v && rdy) m_q.push_back('{pc, tgt, tk, cd});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          v  pc        tgt       tk cd s  rdy cnt st btb bim e_pc      e_tgt     e_tk
    tbl[0]  = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  0,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[1]  = '{1, 32'h1000, 32'h2000, 1, 1, 0, 1,  0,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[2]  = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  1,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[3]  = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  0,  0, 1,  1,  32'h1000, 32'h2000, 1};
    tbl[4]  = '{1, 32'h3000, 32'h3004, 0, 1, 0, 1,  0,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[5]  = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  1,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[6]  = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  0,  0, 0,  1,  32'h3000, 32'h0,    0};
    tbl[7]  = '{1, 32'h100,  32'h200,  1, 0, 1, 1,  0,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[8]  = '{1, 32'h110,  32'h210,  1, 1, 1, 1,  1,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[9]  = '{1, 32'h120,  32'h220,  0, 1, 1, 1,  2,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[10] = '{1, 32'h130,  32'h230,  1, 1, 1, 1,  3,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[11] = '{1, 32'h140,  32'h240,  1, 1, 1, 0,  4,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[12] = '{1, 32'h140,  32'h240,  1, 1, 1, 0,  4,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[13] = '{0, 32'h0,    32'h0,    0, 0, 0, 0,  4,  0, 0,  0,  32'h0,    32'h0,    0};
    tbl[14] = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  3,  0, 1,  0,  32'h100,  32'h200,  1};
    tbl[15] = '{1, 32'h150,  32'h250,  1, 1, 0, 1,  2,  0, 1,  1,  32'h110,  32'h210,  1};
    tbl[16] = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  2,  0, 0,  1,  32'h120,  32'h0,    0};
    tbl[17] = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  1,  0, 1,  1,  32'h130,  32'h230,  1};
    tbl[18] = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  0,  0, 1,  1,  32'h150,  32'h250,  1};
    tbl[19] = '{0, 32'h0,    32'h0,    0, 0, 0, 1,  0,  0, 0,  0,  32'h0,    32'h0,    0};

    // reset state while reset is held
    @(negedge i_clk);
    #1;
    chk("rst_btb_v", o_btb_upd_valid, 1'b0);
    chk("rst_bim_v", o_bim_upd_valid, 1'b0);
    chk("rst_stall", o_search_stall, 1'b0);
    chk("rst_count", o_q_count, 0);
    chk("rst_ready", o_upd_ready, 1'b1);
    chk("rst_btb_pc", o_btb_upd_pc, 0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // directed vector table
    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].pc, tbl[i].tgt, tbl[i].tk, tbl[i].cd, tbl[i].s);
      chk($sformatf("tbl%0d_ready", i), o_upd_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_count", i), o_q_count, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_stall", i), o_search_stall, tbl[i].e_stall);
      chk($sformatf("tbl%0d_btb_v", i), o_btb_upd_valid, tbl[i].e_btb);
      chk($sformatf("tbl%0d_bim_v", i), o_bim_upd_valid, tbl[i].e_bim);
      if (tbl[i].e_btb) begin
        chk($sformatf("tbl%0d_btb_pc", i), o_btb_upd_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_btb_tgt", i), o_btb_upd_target, tbl[i].e_tgt);
      end
      if (tbl[i].e_bim) begin
        chk($sformatf("tbl%0d_bim_pc", i), o_bim_upd_pc, tbl[i].e_pc);
        chk($sformatf("tbl%0d_bim_tk", i), o_bim_upd_taken, tbl[i].e_tk);
      end
    end

    // starvation: forced drain in the STARVE_MAX-th blocked cycle
    drive(1, 32'h700, 32'h704, 1, 0, 1);
    for (int k = 1; k <= STARVE_MAX; k++) begin
      drive(0, 32'h0, 32'h0, 0, 0, 1);
      chk($sformatf("starve%0d_stall", k), o_search_stall, (k == STARVE_MAX));
      chk($sformatf("starve%0d_count", k), o_q_count, 1);
      chk($sformatf("starve%0d_btb_v", k), o_btb_upd_valid, 1'b0);
    end
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    chk("starve_after_stall", o_search_stall, 1'b0);
    chk("starve_after_btb_v", o_btb_upd_valid, 1'b1);
    chk("starve_after_pc", o_btb_upd_pc, 32'h700);
    chk("starve_after_count", o_q_count, 0);
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    chk("starve_strobe_once", o_btb_upd_valid, 1'b0);

    // asynchronous reset with queued entries and a strobe in flight
    drive(1, 32'h800, 32'h900, 1, 1, 1);
    drive(1, 32'h810, 32'h910, 1, 1, 1);
    drive(1, 32'h820, 32'h920, 1, 1, 1);
    drive(1, 32'h830, 32'h930, 1, 1, 0);
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    chk("prerst_count", o_q_count, 3);
    chk("prerst_btb_v", o_btb_upd_valid, 1'b1);
    chk("prerst_pc", o_btb_upd_pc, 32'h800);
    i_reset = 1'b1;
    #1;
    chk("arst_btb_v", o_btb_upd_valid, 1'b0);
    chk("arst_bim_v", o_bim_upd_valid, 1'b0);
    chk("arst_count", o_q_count, 0);
    chk("arst_ready", o_upd_ready, 1'b1);
    chk("arst_btb_pc", o_btb_upd_pc, 0);
    chk("arst_btb_tgt", o_btb_upd_target, 0);
    @(negedge i_clk);
    i_reset = 1'b0;

`ifdef MSRH_UPD_COALESCE_EN
    drive(1, 32'h4000, 32'h5000, 1, 1, 1);
    drive(1, 32'h4000, 32'h6000, 1, 1, 1);
    chk("coal_count1", o_q_count, 1);
    drive(0, 32'h0, 32'h0, 0, 0, 1);
    chk("coal_count2", o_q_count, 1);
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    chk("coal_btb_v", o_btb_upd_valid, 1'b1);
    chk("coal_tgt", o_btb_upd_target, 32'h6000);
    chk("coal_count3", o_q_count, 0);
`endif

    // randomized run against the reference model
    do_reset();
    begin
      logic [31:0] pc_ctr;
      int          busy;
      pc_ctr = 32'h1_0000;
      busy   = 9;
      for (int c = 0; c < 600; c++) begin
        logic        v, s, tk, cd;
        logic [31:0] tgt;
        if ((c % 16) == 0) busy = (($urandom_range(0, 1) == 0) ? 10 : 5);
        v      = ($urandom_range(0, 1) == 1);
        s      = ($urandom_range(0, 9) < busy);
        tk     = ($urandom_range(0, 1) == 1);
        cd     = tk ? ($urandom_range(0, 1) == 1) : 1'b1;
        tgt    = $urandom;
        pc_ctr = pc_ctr + 32'd4;
        drive(v, pc_ctr, tgt, tk, cd, s);
        model_cycle(v, pc_ctr, tgt, tk, cd, s);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
